ped_walk_agent: RTL and testbench
=================================

# ped_walk_agent

Pedestrian-domain end of the walk-request toggle handshake. Debounces the crossing button, issues a request toggle toward the main domain, waits for the synchronized grant toggle, drives the walk indication for a fixed interval, then returns an acknowledge toggle that releases the main domain's red hold. Sits in the pedestrian clock domain, between the button pad and the grant/request/ack synchronizers.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable-high samples required before a press is accepted (≥2)
- WALK_CYCLES, 16: cycles `walk` is held high per grant (≥1)
- FLASH_CYCLES, 8: clearance-flash cycles after walk (used only with the flash feature, ≥1)
- COOLDOWN_CYCLES, 8: minimum cycles after ack before a new request is issued (≥1)
- CNT_W, 8: width of the shared phase counter; every cycle parameter must be ≤ 2^CNT_W
- clk_ped  input  1  pedestrian-domain clock; all logic on its rising edge
- rst_ped  input  1  asynchronous, active-high reset
- button  input  1  raw asynchronous button level; synchronized internally
- grant_sync  input  1  grant toggle, already synchronized into clk_ped
- req_toggle_out  output  1  request toggle to main domain; flips once per request
- ack_toggle_out  output  1  acknowledge toggle to main domain; flips once per completed walk
- walk  output  1  walk indication, registered
- walk_flash  output  1  clearance-flash indication, registered; constant 0 without the flash feature
- busy  output  1  high in every state except IDLE

## Operation
- Button path: 2-flop synchronizer, then debounce. The debounced level goes high after DEBOUNCE_CYCLES consecutive high synchronized samples and goes low on the first low sample. A rising edge of the debounced level is a one-cycle press pulse.
- States: IDLE, REQ, WALK, FLASH (flash feature only), COOLDOWN.
- IDLE: on a press, flip req_toggle_out and enter REQ.
- REQ: wait for a grant edge (grant_sync ≠ prev_grant). On the edge, load the counter with WALK_CYCLES-1 and enter WALK.
- WALK: walk=1. Decrement the counter each cycle. At 0, with the feature: load FLASH_CYCLES-1 and enter FLASH. Without the feature: flip ack_toggle_out, load COOLDOWN_CYCLES-1 and enter COOLDOWN.
- FLASH: walk=0, walk_flash=1. At 0, flip ack_toggle_out, load COOLDOWN_CYCLES-1 and enter COOLDOWN.
- COOLDOWN: a press sets pending_press. At 0: if pending_press, flip req_toggle_out, clear pending_press and enter REQ. Otherwise enter IDLE.
- Presses in REQ, WALK and FLASH are dropped. pending_press holds at most one press.
- prev_grant updates every cycle in every state.
- A grant edge outside REQ is ignored; it is an unsolicited or stale grant.
- Each toggle flips at most once per cycle. req and ack never flip in the same cycle.

## Timing
- Reset values: req_toggle_out=0, ack_toggle_out=0, walk=0, walk_flash=0, busy=0, state=IDLE, counter=0, pending_press=0, prev_grant=0, synchronizer and debounce state=0.
- Button to press pulse: 2 synchronizer cycles + DEBOUNCE_CYCLES.
- Press pulse to req_toggle_out flip: the same clock edge that registers the pulse; REQ is entered on that edge.
- Grant edge sampled at edge N: walk=1 from edge N+1 through N+WALK_CYCLES.
- walk falls and walk_flash rises on the same edge. No gap, no overlap.
- ack_toggle_out flips on the edge that ends the final walk or flash cycle.
- After ack, COOLDOWN lasts exactly COOLDOWN_CYCLES cycles before IDLE or REQ.
- Reset mid-operation: all outputs return to reset values asynchronously. The main domain must be reset in the same event so that the toggle parity is preserved.

## Configuration
- PED_FLASH_EN defined: the FLASH state is present, and walk_flash is driven for FLASH_CYCLES after WALK.
- PED_FLASH_EN undefined: the FLASH state and its logic are removed, walk_flash is tied to 0, and ack follows WALK directly.

## Structure
- Shared package: state encoding enum (IDLE, REQ, WALK, FLASH, COOLDOWN) and the default cycle-count constants.
- Sub-module: ped_btn_debounce, which contains the button synchronizer, the debounce counter and the press-pulse generator.

## Test plan
- Press in IDLE, defaults: button high for 10 cycles → req_toggle_out 0→1 at 2+4 cycles. Grant toggle 0→1 → walk high for exactly 16 cycles. Then ack_toggle_out 0→1 and busy high for 8 more cycles.
- Bounce: button high 3 cycles, low 1, high 3 → no request. Button high 4 cycles → exactly one req flip.
- PED_FLASH_EN: walk 16 cycles, then walk_flash 8 cycles with no gap, then ack flip. Without the macro, walk_flash stays 0 and ack flips right after walk.
- Press during COOLDOWN → req_toggle_out flips at cooldown end and REQ is entered without returning to IDLE. Presses during WALK → no extra request.
- Unsolicited grant toggle in IDLE → walk stays 0. A later press plus a real grant edge → a normal 16-cycle walk.
- rst_ped asserted mid-WALK → walk, busy and both toggles return to 0 immediately. After release, a new press starts a fresh request.

Source files
------------

// File: rtl/ped_walk_agent_pkg.sv
// Shared state encoding and default cycle counts for the pedestrian walk agent.
// The optional clearance-flash phase is enabled by defining PED_FLASH_EN.
package ped_walk_agent_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_WALK_CYCLES     = 16;
  localparam int DEF_FLASH_CYCLES    = 8;
  localparam int DEF_COOLDOWN_CYCLES = 8;
  localparam int DEF_CNT_W           = 8;

  typedef logic [2:0] ped_state_t;

  localparam ped_state_t ST_IDLE     = 3'd0;
  localparam ped_state_t ST_REQ      = 3'd1;
  localparam ped_state_t ST_WALK     = 3'd2;
  localparam ped_state_t ST_FLASH    = 3'd3;
  localparam ped_state_t ST_COOLDOWN = 3'd4;

endpackage

// File: rtl/ped_btn_debounce.sv
// Button synchronizer and debouncer; press is a one-cycle pulse on the debounced rising edge.
// The pulse is combinational so the consumer registers it on the same edge the level rises.
import ped_walk_agent_pkg::*;

module ped_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_ped,
  input  logic rst_ped,
  input  logic button,
  output logic press
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync_1;
  logic            sync_2;
  logic [DB_W-1:0] db_cnt;
  logic            db_level;

  always_ff @(posedge clk_ped or posedge rst_ped) begin
    if (rst_ped) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= button;
      sync_2 <= sync_1;
    end
  end

  // Counts consecutive high samples; the final sample raises the level and the pulse together.
  always_ff @(posedge clk_ped or posedge rst_ped) begin
    if (rst_ped) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (!sync_2) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (!db_level) begin
      if (db_cnt == DB_LAST) begin
        db_level <= 1'b1;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = sync_2 && !db_level && (db_cnt == DB_LAST);

endmodule

// File: rtl/ped_walk_agent.sv
// Pedestrian end of the walk-request toggle handshake: request, walk, optional flash, ack, cooldown.
// Define PED_FLASH_EN to add the clearance-flash phase between walk and ack.
import ped_walk_agent_pkg::*;

module ped_walk_agent #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int WALK_CYCLES     = DEF_WALK_CYCLES,
  parameter int FLASH_CYCLES    = DEF_FLASH_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk_ped,
  input  logic rst_ped,
  input  logic button,
  input  logic grant_sync,
  output logic req_toggle_out,
  output logic ack_toggle_out,
  output logic walk,
  output logic walk_flash,
  output logic busy
);

  localparam logic [CNT_W-1:0] WALK_LOAD = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || WALK_CYCLES < 1 || FLASH_CYCLES < 1 || COOLDOWN_CYCLES < 1 ||
      WALK_CYCLES > 2**CNT_W || FLASH_CYCLES > 2**CNT_W || COOLDOWN_CYCLES > 2**CNT_W) begin : g_bad_params
    $error("ped_walk_agent: cycle parameter out of range");
  end

  ped_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             pending_press;
  logic             prev_grant;
  logic             press;
  logic             grant_edge;

  ped_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_ped(clk_ped),
    .rst_ped(rst_ped),
    .button (button),
    .press  (press)
  );

  assign grant_edge = (grant_sync != prev_grant);
  assign busy       = (state != ST_IDLE);

`ifdef PED_FLASH_EN
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
  logic flash_q;
  assign walk_flash = flash_q;
`else
  assign walk_flash = 1'b0;
`endif

  // A press on the final cooldown cycle still counts as pending rather than being lost.
  always_ff @(posedge clk_ped or posedge rst_ped) begin
    if (rst_ped) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      pending_press  <= 1'b0;
      prev_grant     <= 1'b0;
      req_toggle_out <= 1'b0;
      ack_toggle_out <= 1'b0;
      walk           <= 1'b0;
`ifdef PED_FLASH_EN
      flash_q        <= 1'b0;
`endif
    end else begin
      prev_grant <= grant_sync;
      case (state)
        ST_IDLE: begin
          if (press) begin
            req_toggle_out <= ~req_toggle_out;
            state          <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (grant_edge) begin
            cnt   <= WALK_LOAD;
            walk  <= 1'b1;
            state <= ST_WALK;
          end
        end
        ST_WALK: begin
          if (cnt == '0) begin
            walk <= 1'b0;
`ifdef PED_FLASH_EN
            flash_q <= 1'b1;
            cnt     <= FLASH_LOAD;
            state   <= ST_FLASH;
`else
            ack_toggle_out <= ~ack_toggle_out;
            cnt            <= COOL_LOAD;
            state          <= ST_COOLDOWN;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef PED_FLASH_EN
        ST_FLASH: begin
          if (cnt == '0) begin
            flash_q        <= 1'b0;
            ack_toggle_out <= ~ack_toggle_out;
            cnt            <= COOL_LOAD;
            state          <= ST_COOLDOWN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        ST_COOLDOWN: begin
          if (cnt == '0) begin
            pending_press <= 1'b0;
            if (pending_press || press) begin
              req_toggle_out <= ~req_toggle_out;
              state          <= ST_REQ;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
            if (press) begin
              pending_press <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ped_walk_agent.sv
// Scoreboard bench for ped_walk_agent; expected request and walk-sequence results are queued at stimulus time.
// Builds with or without PED_FLASH_EN, matching the design under test.
module tb_ped_walk_agent;

  localparam int DEB  = 4;
  localparam int WALK = 16;
  localparam int COOL = 8;
`ifdef PED_FLASH_EN
  localparam int FLASH = 8;
`else
  localparam int FLASH = 0;
`endif

  typedef struct {
    int   walk_len;
    int   flash_len;
    logic ack_val;
    logic ack_after_walk;
    logic first_flash;
  } walk_exp_t;

  logic clk_ped    = 1'b0;
  logic rst_ped    = 1'b1;
  logic button     = 1'b0;
  logic grant_sync = 1'b0;
  logic req_toggle_out;
  logic ack_toggle_out;
  logic walk;
  logic walk_flash;
  logic busy;

  int errors = 0;
  int checks = 0;

  walk_exp_t walk_q[$];
  logic      req_q[$];

  ped_walk_agent dut (
    .clk_ped       (clk_ped),
    .rst_ped       (rst_ped),
    .button        (button),
    .grant_sync    (grant_sync),
    .req_toggle_out(req_toggle_out),
    .ack_toggle_out(ack_toggle_out),
    .walk          (walk),
    .walk_flash    (walk_flash),
    .busy          (busy)
  );

  always #5 clk_ped = ~clk_ped;

  task automatic step(input int n);
    repeat (n) @(negedge clk_ped);
  endtask

  // Holds the button for 'hold' cycles and reports when req_toggle_out first moves.
  task automatic press_measure(input int hold, output int lat, output logic val);
    logic r0;
    r0     = req_toggle_out;
    lat    = -1;
    val    = r0;
    button = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (i == hold) button = 1'b0;
      if (lat < 0 && req_toggle_out !== r0) begin
        lat = i;
        val = req_toggle_out;
      end
      if (lat >= 0 && i >= hold) break;
    end
    button = 1'b0;
  endtask

  // Toggles the grant and measures the resulting walk / flash / cooldown phases.
  task automatic grant_measure(output int wl, output int fl, output logic first_flash,
                               output logic ack_after_walk, output logic ack_val, output int cool);
    wl = 0; fl = 0; cool = 0;
    grant_sync = ~grant_sync;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (walk === 1'b1) break;
    end
    while (walk === 1'b1 && wl < 200) begin
      wl++;
      step(1);
    end
    first_flash    = walk_flash;
    ack_after_walk = ack_toggle_out;
    while (walk_flash === 1'b1 && fl < 200) begin
      fl++;
      step(1);
    end
    ack_val = ack_toggle_out;
    while (busy === 1'b1 && cool < 200) begin
      cool++;
      step(1);
    end
  endtask

  task automatic expect_walk();
    walk_exp_t e;
    e.walk_len       = WALK;
    e.flash_len      = FLASH;
    e.ack_val        = ~ack_toggle_out;
    e.ack_after_walk = (FLASH > 0) ? ack_toggle_out : ~ack_toggle_out;
    e.first_flash    = (FLASH > 0);
    walk_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_ped = 1'b1;
    step(3);
    checks++; if (req_toggle_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b want 0", req_toggle_out); end
    checks++; if (ack_toggle_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b want 0", ack_toggle_out); end
    checks++; if (walk !== 1'b0) begin errors++; $display("[TB] FAIL reset_walk: got %b want 0", walk); end
    checks++; if (walk_flash !== 1'b0) begin errors++; $display("[TB] FAIL reset_flash: got %b want 0", walk_flash); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    rst_ped = 1'b0;
    step(2);
  endtask

  task automatic test_press_walk(input string tag);
    int lat; logic val; logic exp_req;
    int wl, fl, cool; logic ff, aw, av;
    walk_exp_t e;
    req_q.push_back(~req_toggle_out);
    press_measure(10, lat, val);
    exp_req = req_q.pop_front();
    checks++; if (lat !== DEB + 2) begin errors++; $display("[TB] FAIL %s_req_latency: got %0d want %0d", tag, lat, DEB + 2); end
    checks++; if (val !== exp_req) begin errors++; $display("[TB] FAIL %s_req_value: got %b want %b", tag, val, exp_req); end
    expect_walk();
    grant_measure(wl, fl, ff, aw, av, cool);
    e = walk_q.pop_front();
    checks++; if (wl !== e.walk_len) begin errors++; $display("[TB] FAIL %s_walk_len: got %0d want %0d", tag, wl, e.walk_len); end
    checks++; if (ff !== e.first_flash) begin errors++; $display("[TB] FAIL %s_flash_handover: got %b want %b", tag, ff, e.first_flash); end
    checks++; if (aw !== e.ack_after_walk) begin errors++; $display("[TB] FAIL %s_ack_after_walk: got %b want %b", tag, aw, e.ack_after_walk); end
    checks++; if (fl !== e.flash_len) begin errors++; $display("[TB] FAIL %s_flash_len: got %0d want %0d", tag, fl, e.flash_len); end
    checks++; if (av !== e.ack_val) begin errors++; $display("[TB] FAIL %s_ack_value: got %b want %b", tag, av, e.ack_val); end
    checks++; if (cool !== COOL) begin errors++; $display("[TB] FAIL %s_cooldown_len: got %0d want %0d", tag, cool, COOL); end
  endtask

  task automatic test_bounce();
    logic r0; int lat; logic val; logic exp_req;
    r0 = req_toggle_out;
    button = 1'b1; step(3);
    button = 1'b0; step(1);
    button = 1'b1; step(3);
    button = 1'b0; step(12);
    checks++; if (req_toggle_out !== r0) begin errors++; $display("[TB] FAIL bounce_no_req: got %b want %b", req_toggle_out, r0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bounce_idle: busy got %b want 0", busy); end
    req_q.push_back(~req_toggle_out);
    press_measure(4, lat, val);
    exp_req = req_q.pop_front();
    checks++; if (lat !== DEB + 2) begin errors++; $display("[TB] FAIL bounce_press_latency: got %0d want %0d", lat, DEB + 2); end
    step(10);
    checks++; if (req_toggle_out !== exp_req) begin errors++; $display("[TB] FAIL bounce_single_flip: got %b want %b", req_toggle_out, exp_req); end
    begin
      int wl, fl, cool; logic ff, aw, av; walk_exp_t e;
      expect_walk();
      grant_measure(wl, fl, ff, aw, av, cool);
      e = walk_q.pop_front();
      checks++; if (wl !== e.walk_len) begin errors++; $display("[TB] FAIL bounce_walk_len: got %0d want %0d", wl, e.walk_len); end
      checks++; if (av !== e.ack_val) begin errors++; $display("[TB] FAIL bounce_ack_value: got %b want %b", av, e.ack_val); end
    end
  endtask

  task automatic test_cooldown_press();
    int lat; logic val; logic exp_req; logic r1; logic a0;
    int clat; logic busy_drop; logic ack_seen;
    req_q.push_back(~req_toggle_out);
    press_measure(10, lat, val);
    exp_req = req_q.pop_front();
    checks++; if (val !== exp_req) begin errors++; $display("[TB] FAIL cool_first_req: got %b want %b", val, exp_req); end
    a0 = ack_toggle_out;
    grant_sync = ~grant_sync;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (walk === 1'b1) break;
    end
    r1 = req_toggle_out;
    button = 1'b1; step(6);
    button = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (ack_toggle_out !== a0) begin
        ack_seen = 1'b1;
        break;
      end
      step(1);
    end
    checks++; if (ack_seen !== 1'b1) begin errors++; $display("[TB] FAIL cool_ack_seen: got %b want 1", ack_seen); end
    checks++; if (req_toggle_out !== r1) begin errors++; $display("[TB] FAIL walk_press_dropped: req got %b want %b", req_toggle_out, r1); end
    req_q.push_back(~req_toggle_out);
    button    = 1'b1;
    clat      = -1;
    busy_drop = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (i == 6) button = 1'b0;
      if (busy !== 1'b1) busy_drop = 1'b1;
      if (req_toggle_out !== r1) begin
        clat = i;
        break;
      end
    end
    button  = 1'b0;
    exp_req = req_q.pop_front();
    checks++; if (clat !== COOL) begin errors++; $display("[TB] FAIL cool_req_latency: got %0d want %0d", clat, COOL); end
    checks++; if (req_toggle_out !== exp_req) begin errors++; $display("[TB] FAIL cool_req_value: got %b want %b", req_toggle_out, exp_req); end
    checks++; if (busy_drop !== 1'b0) begin errors++; $display("[TB] FAIL cool_no_idle: busy dropped got %b want 0", busy_drop); end
    begin
      int wl, fl, cool; logic ff, aw, av; walk_exp_t e;
      expect_walk();
      grant_measure(wl, fl, ff, aw, av, cool);
      e = walk_q.pop_front();
      checks++; if (wl !== e.walk_len) begin errors++; $display("[TB] FAIL cool_walk_len: got %0d want %0d", wl, e.walk_len); end
      checks++; if (cool !== COOL) begin errors++; $display("[TB] FAIL cool_second_cooldown: got %0d want %0d", cool, COOL); end
    end
  endtask

  task automatic test_unsolicited_grant();
    logic walk_seen; logic busy_seen;
    walk_seen = 1'b0;
    busy_seen = 1'b0;
    grant_sync = ~grant_sync;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (walk !== 1'b0) walk_seen = 1'b1;
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    checks++; if (walk_seen !== 1'b0) begin errors++; $display("[TB] FAIL unsolicited_walk: got %b want 0", walk_seen); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("[TB] FAIL unsolicited_busy: got %b want 0", busy_seen); end
    test_press_walk("after_unsolicited");
  endtask

  task automatic test_reset_mid_walk();
    for (int i = 0; i < 3; i++) step(1);
    button = 1'b1; step(10); button = 1'b0;
    grant_sync = ~grant_sync;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (walk === 1'b1) break;
    end
    step(5);
    checks++; if (walk !== 1'b1) begin errors++; $display("[TB] FAIL midwalk_active: walk got %b want 1", walk); end
    rst_ped = 1'b1;
    #1;
    checks++; if (walk !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_walk: got %b want 0", walk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_busy: got %b want 0", busy); end
    checks++; if (req_toggle_out !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_req: got %b want 0", req_toggle_out); end
    checks++; if (ack_toggle_out !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_ack: got %b want 0", ack_toggle_out); end
    grant_sync = 1'b0;
    step(2);
    rst_ped = 1'b0;
    step(2);
    test_press_walk("post_reset");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_press_walk("basic");
    test_bounce();
    test_cooldown_press();
    test_unsolicited_grant();
    test_reset_mid_walk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
